psum_accum_line_buffer: RTL and testbench
=========================================

// Module: psum_accum_line_buffer
// PURPOSE
//  Receiving end of the line_kcpe engine psum output (o_psum / o_psum_val). Accumulates one line of
//  NUM_KERNEL-lane partial sums across cfg_num_pass channel-group passes in on-chip RAM.
//  After the last pass it streams the final line out over a valid/ready port to the writeback path.
//  Sits between the conv2d engine array and the output DMA / activation stage.
// PARAMETERS
//  BIT_WIDTH   8   width of one psum lane (signed, two's complement)
//  NUM_KERNEL  4   lanes per beat (one per kernel)
//  LINE_DEPTH  64  max positions per line (RAM depth)
//  ADDR_W      6   clog2(LINE_DEPTH)
//  PASS_W      4   width of pass counter
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset
//  cfg_line_len in   ADDR_W+1             positions per line, sampled on i_start
//  cfg_num_pass in   PASS_W               passes to accumulate, sampled on i_start
//  i_start      in   1                    begin new line (honoured only in IDLE)
//  i_psum       in   BIT_WIDTH*NUM_KERNEL psum beat, lane k at [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k]
//  i_psum_val   in   NUM_KERNEL           per-lane valid from engine
//  o_res        out  BIT_WIDTH*NUM_KERNEL accumulated result, same lane packing
//  o_res_val    out  1                    o_res valid
//  i_res_rdy    in   1                    downstream ready
//  o_busy       out  1                    high in ACCUM or DRAIN
//  o_done       out  1                    one-cycle pulse after last result pops
//  o_err        out  3                    sticky {cfg_err, val_mismatch, overflow_drop}; cleared on accepted i_start
// BEHAVIOUR
//  - Single clock clk; rst synchronous, active-high. Reset: FSM=IDLE, all counters 0, o_res=0,
//    o_res_val=0, o_busy=0, o_done=0, o_err=0. RAM contents are not reset (pass 0 overwrites).
//  - FSM IDLE -> ACCUM on i_start with cfg_line_len in 1..LINE_DEPTH; out of range: stay IDLE, set cfg_err.
//    cfg_num_pass==0 treated as 1. ACCUM -> DRAIN after final write of last pass. DRAIN -> IDLE when
//    last result pops; o_done pulses the cycle after that pop.
//  - Beat accepted in ACCUM when &i_psum_val. Partial valid (|i_psum_val && !&i_psum_val): beat dropped,
//    val_mismatch set. Any valid bit in IDLE/DRAIN: dropped, overflow_drop set. No backpressure to engine.
//  - Accept cycle T: RAM read issued at addr. T+1: pass 0 writes i_psum; pass>0 writes lane-wise
//    saturating add (clamp to [-2^(BW-1), 2^(BW-1)-1]) of stored+incoming.
//  - RMW hazard (cfg_line_len==1 or back-to-back same addr): write data of T+1 forwarded into add at T+2.
//  - addr increments per accepted beat; at cfg_line_len-1 wraps to 0 and pass increments.
//    Beat at addr=len-1 on pass num_pass-1 is the last; FSM enters DRAIN at T+2.
//  - DRAIN: sequential reads addr 0..len-1, 1-cycle RAM latency, 2-entry output skid so that with
//    i_res_rdy held high o_res_val is continuous; first o_res_val exactly 3 cycles after last accept.
//    o_res/o_res_val hold stable while o_res_val && !i_res_rdy. Pop = o_res_val && i_res_rdy.
//  - Simultaneous: i_start during ACCUM/DRAIN ignored (no error). Reset mid-operation aborts
//    line immediately, no o_done.
// STRUCTURE
//  - Shared package psum_pkg: FSM state enum {IDLE, ACCUM, DRAIN}, err bit indices, sat_add function.
//  - One sub-module: psum_sdp_ram (simple dual-port, 1 write + 1 registered read, width
//    BIT_WIDTH*NUM_KERNEL, depth LINE_DEPTH). FSM, RMW pipeline, forwarding, skid in top.
// TESTING
//  1 len=4 pass=1, beats lane values 1..4 -> o_res 4 beats equal inputs, o_done once, o_err=0.
//  2 len=3 pass=3, every beat all lanes=10 -> 3 results all lanes=30.
//  3 len=2 pass=2, lane0 100+100 -> lane0=127 (sat); lane1 -100+-100 -> -128.
//  4 len=1 pass=4, back-to-back beats of 5 -> single result 20 (forwarding checked).
//  5 DRAIN with i_res_rdy toggling 1010..., len=8 -> 8 ordered beats, o_res stable during stalls.
//  6 i_psum_val=4'b0111 in ACCUM -> beat dropped, o_err[1]=1; start with len=0 -> o_err[2]=1, stays IDLE;
//    rst mid-ACCUM -> all outputs 0 next cycle, new line after restart correct.

Source files
------------

// File: rtl/psum_pkg.sv
// psum_pkg: shared FSM state type, sticky error bit positions and lane saturating add
package psum_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

    localparam int ERR_OVF = 0;
    localparam int ERR_VAL = 1;
    localparam int ERR_CFG = 2;

    // Operands arrive sign-extended to int; the result is clamped to a bw-bit signed range.
    function automatic int sat_add(input int a, input int b, input int bw);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (bw - 1)) - 1;
        lo = -(1 << (bw - 1));
        return (s > hi) ? hi : ((s < lo) ? lo : s);
    endfunction

endpackage

// File: rtl/psum_sdp_ram.sv
// psum_sdp_ram: simple dual-port RAM, one write port and one registered read port
//   clk_i     clock
//   we_i      write enable, waddr_i/wdata_i write address/data
//   re_i      read enable, raddr_i read address, rdata_o read data one cycle later
module psum_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // A read and a write to the same address on one edge return the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/psum_accum_line_buffer.sv
// psum_accum_line_buffer: accumulates one line of multi-lane psums over several passes, then drains it
//   clk, rst                     clock, synchronous active-high reset
//   cfg_line_len, cfg_num_pass   line length and pass count, sampled on i_start
//   i_start                      begin a new line (IDLE only)
//   i_psum, i_psum_val           engine psum beat and per-lane valid
//   o_res, o_res_val, i_res_rdy  valid/ready result stream
//   o_busy, o_done, o_err        status: busy, one-cycle done pulse, sticky {cfg, val_mismatch, overflow}
module psum_accum_line_buffer
    import psum_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int LINE_DEPTH = 64,
    parameter int ADDR_W     = 6,
    parameter int PASS_W     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W:0]                  cfg_line_len,
    input  logic [PASS_W-1:0]                cfg_num_pass,
    input  logic                             i_start,
    input  logic [BIT_WIDTH*NUM_KERNEL-1:0]  i_psum,
    input  logic [NUM_KERNEL-1:0]            i_psum_val,
    output logic [BIT_WIDTH*NUM_KERNEL-1:0]  o_res,
    output logic                             o_res_val,
    input  logic                             i_res_rdy,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [2:0]                       o_err
);

    localparam int DW = BIT_WIDTH * NUM_KERNEL;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(LINE_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, addr_q, addr_d, pcnt_q, pcnt_d;
    logic [PASS_W-1:0] pass_q, pass_d, npass_q, npass_d;
    logic [2:0]        err_q, err_d;
    logic              done_q, done_d;

    logic              s1_val_q, s1_first_q, s1_last_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [DW-1:0]     s1_data_q;
    logic              s2_val_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [DW-1:0]     s2_data_q;

    logic              r_val_q;
    logic [1:0]        cnt_q, cnt_d, wpos;
    logic [DW-1:0]     sk0_q, sk0_d, sk1_q, sk1_d;

    logic              accept, wrap, last_beat, cfg_ok, pop, pop_sk, push, drain_rd;
    logic [DW-1:0]     rdata, base, wdata;

    // After the final beat is accepted the line is closed; later valid beats count as overflow.
    assign accept    = state_q == ACCUM && !s1_last_q && &i_psum_val;
    assign wrap      = addr_q == len_q - 1'b1;
    assign last_beat = wrap && pass_q == npass_q - 1'b1;
    assign cfg_ok    = cfg_line_len != '0 && cfg_line_len <= DEPTH_L;

    assign o_res_val = cnt_q != 2'd0 || r_val_q;
    assign o_res     = cnt_q != 2'd0 ? sk0_q : (r_val_q ? rdata : '0);
    assign o_busy    = state_q != IDLE;
    assign o_done    = done_q;
    assign o_err     = err_q;

    assign pop    = o_res_val && i_res_rdy;
    assign pop_sk = pop && cnt_q != 2'd0;
    assign push   = r_val_q && !(pop && cnt_q == 2'd0);
    assign cnt_d  = cnt_q - 2'(pop_sk) + 2'(push);
    assign wpos   = cnt_q - 2'(pop_sk);
    // Only issue a read when the data returning next cycle is guaranteed a skid slot.
    assign drain_rd = state_q == DRAIN && addr_q != len_q && cnt_d != 2'd2;

    // Back-to-back hits on one address see stale RAM data; take the value just written instead.
    assign base = (s2_val_q && s2_addr_q == s1_addr_q) ? s2_data_q : rdata;

    psum_sdp_ram #(.WIDTH(DW), .DEPTH(LINE_DEPTH), .AW(ADDR_W)) u_ram (
        .clk_i   (clk),
        .we_i    (s1_val_q),
        .waddr_i (s1_addr_q),
        .wdata_i (wdata),
        .re_i    (accept || drain_rd),
        .raddr_i (addr_q[ADDR_W-1:0]),
        .rdata_o (rdata)
    );

    always_comb begin
        wdata = s1_data_q;
        for (int k = 0; k < NUM_KERNEL; k++)
            if (!s1_first_q)
                wdata[k*BIT_WIDTH +: BIT_WIDTH] = BIT_WIDTH'(sat_add(
                    int'($signed(base[k*BIT_WIDTH +: BIT_WIDTH])),
                    int'($signed(s1_data_q[k*BIT_WIDTH +: BIT_WIDTH])), BIT_WIDTH));
    end

    always_comb begin
        sk0_d = pop_sk ? sk1_q : sk0_q;
        if (push && wpos == 2'd0) sk0_d = rdata;
        sk1_d = (push && wpos == 2'd1) ? rdata : sk1_q;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        npass_d = npass_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q == IDLE && i_start) begin
            if (cfg_ok) begin
                state_d = ACCUM;
                len_d   = cfg_line_len;
                npass_d = cfg_num_pass == '0 ? PASS_W'(1) : cfg_num_pass;
                addr_d  = '0;
                pass_d  = '0;
                pcnt_d  = '0;
                err_d   = '0;
            end else begin
                err_d[ERR_CFG] = 1'b1;
            end
        end
        if (accept) begin
            addr_d = wrap ? '0 : addr_q + 1'b1;
            pass_d = wrap ? pass_q + 1'b1 : pass_q;
        end
        if (state_q == ACCUM && s1_val_q && s1_last_q) state_d = DRAIN;
        if (drain_rd) addr_d = addr_q + 1'b1;
        if (pop) begin
            pcnt_d = pcnt_q + 1'b1;
            if (pcnt_q == len_q - 1'b1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
        if (state_q == ACCUM && |i_psum_val && !(&i_psum_val)) err_d[ERR_VAL] = 1'b1;
        if ((state_q != ACCUM || s1_last_q) && |i_psum_val) err_d[ERR_OVF] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            npass_q    <= '0;
            addr_q     <= '0;
            pass_q     <= '0;
            pcnt_q     <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            s1_val_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            s2_val_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            r_val_q    <= 1'b0;
            cnt_q      <= '0;
            sk0_q      <= '0;
            sk1_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            npass_q    <= npass_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            pcnt_q     <= pcnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            s1_val_q   <= accept;
            s1_first_q <= pass_q == '0;
            s1_last_q  <= accept && last_beat;
            s1_addr_q  <= addr_q[ADDR_W-1:0];
            s1_data_q  <= i_psum;
            s2_val_q   <= s1_val_q;
            s2_addr_q  <= s1_addr_q;
            s2_data_q  <= wdata;
            r_val_q    <= drain_rd;
            cnt_q      <= cnt_d;
            sk0_q      <= sk0_d;
            sk1_q      <= sk1_d;
        end
    end

endmodule

// File: tb/tb_psum_accum_line_buffer.sv
// tb_psum_accum_line_buffer: directed stimulus with a scoreboard queue checked by a result monitor
module tb_psum_accum_line_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  cfg_line_len = '0;
    logic [3:0]  cfg_num_pass = '0;
    logic        i_start = 1'b0;
    logic [31:0] i_psum = '0;
    logic [3:0]  i_psum_val = '0;
    logic [31:0] o_res;
    logic        o_res_val;
    logic        i_res_rdy = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_err;

    logic [31:0] exp_q[$];
    int          n_pass = 0;
    int          n_tot = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    logic        rdy_tog = 1'b0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    psum_accum_line_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_line_len (cfg_line_len),
        .cfg_num_pass (cfg_num_pass),
        .i_start      (i_start),
        .i_psum       (i_psum),
        .i_psum_val   (i_psum_val),
        .o_res        (o_res),
        .o_res_val    (o_res_val),
        .i_res_rdy    (i_res_rdy),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input int len, input int np);
        cfg_line_len = 7'(len);
        cfg_num_pass = 4'(np);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] v);
        i_psum = d;
        i_psum_val = v;
        tick();
    endtask

    task automatic wait_done;
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (o_done) got = 1'b1;
            else tick();
        end
        chk("done_seen", 64'(got), 64'd1);
        tick();
        done_exp++;
        chk("done_count", 64'(done_cnt), 64'(done_exp));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) begin
        #1;
        i_res_rdy = rdy_tog ? !i_res_rdy : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("stall_hold", {31'd0, o_res_val, o_res}, {31'd0, 1'b1, hold_d});
            if (o_res_val && i_res_rdy) begin
                if (exp_q.size() == 0) chk("unexpected_res", 64'(o_res), 64'hDEAD);
                else chk("res_data", 64'(o_res), 64'(exp_q.pop_front()));
            end
            hold_v = o_res_val && !i_res_rdy;
            hold_d = o_res;
            if (o_done) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("reset_outs", {26'd0, o_res, o_res_val, o_busy, o_done, o_err}, 64'd0);
        rst = 1'b0;
        tick();

        // line 1: len 4, one pass, results equal inputs, first result 3 cycles after last accept
        start_line(4, 1);
        chk("busy_accum", 64'(o_busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pk(1 + 4*i, 2 + 4*i, 3 + 4*i, 4 + 4*i));
            beat(pk(1 + 4*i, 2 + 4*i, 3 + 4*i, 4 + 4*i), 4'hF);
        end
        i_psum_val = 4'h0;
        chk("lat_t1", 64'(o_res_val), 64'd0);
        tick();
        chk("lat_t2", 64'(o_res_val), 64'd0);
        tick();
        chk("lat_t3", 64'(o_res_val), 64'd1);
        wait_done();
        chk("err_t1", 64'(o_err), 64'd0);
        chk("busy_idle", 64'(o_busy), 64'd0);

        // line 2: len 3, three passes of 10
        start_line(3, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(pk(30, 30, 30, 30));
        for (int i = 0; i < 9; i++) beat(pk(10, 10, 10, 10), 4'hF);
        i_psum_val = 4'h0;
        wait_done();

        // line 3: saturation both ways
        start_line(2, 2);
        exp_q.push_back(pk(127, -128, 100, -2));
        exp_q.push_back(pk(2, 4, 6, 8));
        for (int p = 0; p < 2; p++) begin
            beat(pk(100, -100, 50, -1), 4'hF);
            beat(pk(1, 2, 3, 4), 4'hF);
        end
        i_psum_val = 4'h0;
        wait_done();

        // line 4: len 1, back-to-back same address, four passes
        start_line(1, 4);
        exp_q.push_back(pk(20, -20, 127, -128));
        for (int i = 0; i < 4; i++) beat(pk(5, -5, 40, -40), 4'hF);
        i_psum_val = 4'h0;
        wait_done();

        // line 5: len 8 with ready toggling during drain
        start_line(8, 0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pk(16*i, 16*i + 1, -16*i, 7 - i));
            beat(pk(16*i, 16*i + 1, -16*i, 7 - i), 4'hF);
        end
        i_psum_val = 4'h0;
        rdy_tog = 1'b1;
        wait_done();
        rdy_tog = 1'b0;
        tick();

        // line 6: partial valid dropped
        start_line(2, 1);
        exp_q.push_back(pk(9, 8, 7, 6));
        exp_q.push_back(pk(-9, -8, -7, -6));
        beat(pk(9, 8, 7, 6), 4'hF);
        beat(pk(55, 55, 55, 55), 4'b0111);
        beat(pk(-9, -8, -7, -6), 4'hF);
        i_psum_val = 4'h0;
        wait_done();
        chk("err_mismatch", 64'(o_err), 64'b010);

        // invalid lengths stay IDLE and flag cfg_err
        start_line(0, 1);
        chk("err_len0", 64'(o_err), 64'b110);
        chk("idle_len0", 64'(o_busy), 64'd0);
        start_line(65, 1);
        chk("idle_len65", 64'(o_busy), 64'd0);

        // valid beat in IDLE is dropped as overflow
        beat(pk(1, 1, 1, 1), 4'hF);
        i_psum_val = 4'h0;
        chk("err_ovf", 64'(o_err), 64'b111);

        // accepted start clears errors; reset mid-line aborts it
        start_line(3, 1);
        chk("err_cleared", 64'(o_err), 64'd0);
        beat(pk(3, 3, 3, 3), 4'hF);
        i_psum_val = 4'h0;
        rst = 1'b1;
        tick();
        chk("rst_mid_outs", {26'd0, o_res, o_res_val, o_busy, o_done, o_err}, 64'd0);
        rst = 1'b0;
        tick();

        start_line(2, 2);
        exp_q.push_back(pk(11, 22, 33, 44));
        exp_q.push_back(pk(-11, -22, -33, -44));
        beat(pk(1, 2, 3, 4), 4'hF);
        beat(pk(-1, -2, -3, -4), 4'hF);
        beat(pk(10, 20, 30, 40), 4'hF);
        beat(pk(-10, -20, -30, -40), 4'hF);
        i_psum_val = 4'h0;
        wait_done();
        chk("err_final", 64'(o_err), 64'd0);

        repeat (4) tick();
        chk("done_total", 64'(done_cnt), 64'(done_exp));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
